oam_dma_controller: RTL and testbench
=====================================

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have port: clk_ph1  input  1  single system clock; all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: cpu_addr  input  16  CPU output address bus.
REQ-004 SHALL have port: cpu_wdata  input  8  CPU write data.
REQ-005 SHALL have port: cpu_wr  input  1  CPU write strobe for the current cycle.
REQ-006 SHALL have port: bus_rdata  input  8  system read data returned in the same cycle as the address.
REQ-007 SHALL have port: cpu_rdy  output  1  0 = CPU halted.
REQ-008 SHALL have port: bus_grant  output  1  1 = DMA drives address, data and write strobe.
REQ-009 SHALL have port: dma_addr  output  16  DMA address.
REQ-010 SHALL have port: dma_wdata  output  8  DMA write data.
REQ-011 SHALL have port: dma_wr  output  1  DMA write strobe.
REQ-012 SHALL have port: dma_busy  output  1  1 from trigger until the last write completes.

Function
REQ-013 SHALL define trigger: cpu_wr=1 and cpu_addr=16'h4014; page register latches cpu_wdata on that edge.
REQ-014 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 SHALL leave IDLE for HALT on trigger; cpu_rdy=0 and dma_busy=1 from the next cycle.
REQ-016 SHALL remain in HALT while cpu_wr=1, because the CPU cannot halt on a write; HALT lasts at least 1 cycle (dummy).
REQ-017 SHALL maintain a free-running parity flop, 0 after reset and toggling every cycle; READ begins only when parity=0.
REQ-018 SHALL leave HALT for READ if parity=0, else for ALIGN; ALIGN lasts 1 cycle and then goes to READ.
REQ-019 SHALL in READ drive bus_grant=1, dma_addr={page,cnt}, dma_wr=0, and latch bus_rdata at the cycle end.
REQ-020 SHALL in WRITE drive bus_grant=1, dma_addr=16'h2004, dma_wdata=latched byte, dma_wr=1, and increment the 8-bit cnt.
REQ-021 SHALL go from WRITE to READ while cnt!=8'hFF; the WRITE with cnt=8'hFF goes to IDLE, and cnt wraps to 0.
REQ-022 SHALL return cpu_rdy=1, bus_grant=0 and dma_busy=0 in the cycle after the final WRITE.
REQ-023 SHALL complete with no HALT stall in 513 cycles when parity aligns and 514 when it does not, counted from the trigger edge to cpu_rdy=1.
REQ-024 SHALL ignore a trigger while dma_busy=1: page is not reloaded and the transfer is not restarted.
REQ-025 SHALL hold bus_grant=0 in IDLE, HALT and ALIGN, with dma_wr=0 and dma_addr/dma_wdata at 0.

Reset
REQ-026 SHALL on rst=0 immediately force: state IDLE, cpu_rdy=1, bus_grant=0, dma_wr=0, dma_busy=0, dma_addr=0, dma_wdata=0, cnt=0, page=0, parity=0.
REQ-027 SHALL abort an in-progress transfer on reset mid-operation, with no further writes after rst rises.

Configuration
REQ-028 SHALL, with OAM_DMA_ALIGN_EN defined, apply the parity alignment of REQ-017/018 (513/514 cycles).
REQ-029 SHALL, without OAM_DMA_ALIGN_EN, have no ALIGN state and no parity flop; HALT goes directly to READ, giving a fixed 513 cycles.

Structure
REQ-030 SHALL take the state enum, DMA_TRIG_ADDR=16'h4014, OAM_DATA_ADDR=16'h2004 and DMA_LEN=256 from the shared package nes_bus_pkg.
REQ-031 SHALL be a single module with no sub-modules; the bus mux is external and selected by bus_grant.

Verification
REQ-032 SHALL cover: write 8'h02 to $4014 with parity=0 at HALT exit -> 256 READs of 16'h0200..16'h02FF, each followed by a WRITE to 16'h2004, cpu_rdy=1 after 513 cycles.
REQ-033 SHALL cover: the same trigger with parity=1 -> one ALIGN cycle, 514 cycles total; without OAM_DMA_ALIGN_EN -> 513.
REQ-034 SHALL cover: cpu_wr held 1 for 2 cycles after the trigger -> HALT extended by 2 cycles and the first READ delayed accordingly.
REQ-035 SHALL cover: bus_rdata=cnt^8'hA5 -> the dma_wdata sequence equals 8'hA5, 8'hA4, ..., with final byte 8'h5A.
REQ-036 SHALL cover: a second $4014 write mid-transfer -> ignored, and page stays 8'h02.
REQ-037 SHALL cover: rst=0 at transfer byte 100 -> all outputs at reset values asynchronously, and IDLE after release with no dma_wr.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: sprite DMA trigger/target addresses, transfer
// length and the OAM DMA state encoding.
// Optional feature: OAM_DMA_ALIGN_EN adds the ALIGN state used for
// read-cycle parity alignment.
package nes_bus_pkg;

   localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
   localparam int unsigned DMA_LEN       = 256;

   // Byte counter value of the final READ/WRITE pair
   localparam logic [7:0]  LAST_CNT      = 8'(DMA_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3
`ifdef OAM_DMA_ALIGN_EN
      ,
      ALIGN = 3'd4
`endif
   } dma_state_t;

   // A CPU write to the DMA page register starts a transfer
   function automatic logic is_trigger(input logic wr, input logic [15:0] addr);
      return wr && (addr == DMA_TRIG_ADDR);
   endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU/system bus signals seen by the OAM DMA controller.
// master: the DMA controller (drives halt, grant and DMA bus cycle).
// slave : the CPU / system bus side (drives CPU cycle and read data).
interface oam_dma_controller_if;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wr;
   logic [7:0]  bus_rdata;
   logic        cpu_rdy;
   logic        bus_grant;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_wr;
   logic        dma_busy;

   modport master (
      input  cpu_addr, cpu_wdata, cpu_wr, bus_rdata,
      output cpu_rdy, bus_grant, dma_addr, dma_wdata, dma_wr, dma_busy
   );

   modport slave (
      output cpu_addr, cpu_wdata, cpu_wr, bus_rdata,
      input  cpu_rdy, bus_grant, dma_addr, dma_wdata, dma_wr, dma_busy
   );

endinterface

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA controller: a CPU write to $4014 halts the CPU and copies
// 256 bytes from page {page,00..FF} to $2004 as READ/WRITE cycle pairs.
// Optional feature: OAM_DMA_ALIGN_EN enables the free-running parity flop and
// the ALIGN state so the first READ always starts on an even cycle.
// All outputs are registered; the external bus mux selects on bus_grant.
module oam_dma_controller
   import nes_bus_pkg::*;
(
   input logic                  clk_ph1,
   input logic                  rst,
   oam_dma_controller_if.master bus
);

   dma_state_t  state;
   logic [7:0]  page;
   logic [7:0]  cnt;
   logic        cpu_rdy_q;
   logic        bus_grant_q;
   logic [15:0] dma_addr_q;
   logic [7:0]  dma_wdata_q;
   logic        dma_wr_q;
   logic        dma_busy_q;

`ifdef OAM_DMA_ALIGN_EN
   logic        parity;

   // Free-running cycle parity, cleared by reset
   always_ff @(posedge clk_ph1 or negedge rst) begin
      if (!rst) begin
         parity <= 1'b0;
      end else begin
         parity <= ~parity;
      end
   end
`endif

   // Transfer sequencer with registered bus/handshake outputs
   always_ff @(posedge clk_ph1 or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         page        <= '0;
         cnt         <= '0;
         cpu_rdy_q   <= 1'b1;
         bus_grant_q <= 1'b0;
         dma_addr_q  <= '0;
         dma_wdata_q <= '0;
         dma_wr_q    <= 1'b0;
         dma_busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_trigger(bus.cpu_wr, bus.cpu_addr)) begin
                  page       <= bus.cpu_wdata;
                  cnt        <= '0;
                  cpu_rdy_q  <= 1'b0;
                  dma_busy_q <= 1'b1;
                  state      <= HALT;
               end
            end

            HALT: begin
               // The CPU cannot stop mid-write, so wait for a non-write cycle
               if (!bus.cpu_wr) begin
`ifdef OAM_DMA_ALIGN_EN
                  if (parity) begin
                     state <= ALIGN;
                  end else
`endif
                  begin
                     state       <= READ;
                     bus_grant_q <= 1'b1;
                     dma_addr_q  <= {page, cnt};
                  end
               end
            end

`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
               state       <= READ;
               bus_grant_q <= 1'b1;
               dma_addr_q  <= {page, cnt};
            end
`endif

            READ: begin
               // Read data returns in the address cycle; hold it for the write
               state       <= WRITE;
               dma_addr_q  <= OAM_DATA_ADDR;
               dma_wdata_q <= bus.bus_rdata;
               dma_wr_q    <= 1'b1;
            end

            WRITE: begin
               cnt         <= cnt + 8'd1;
               dma_wr_q    <= 1'b0;
               dma_wdata_q <= '0;
               if (cnt == LAST_CNT) begin
                  state       <= IDLE;
                  bus_grant_q <= 1'b0;
                  dma_addr_q  <= '0;
                  cpu_rdy_q   <= 1'b1;
                  dma_busy_q  <= 1'b0;
               end else begin
                  state      <= READ;
                  dma_addr_q <= {page, cnt + 8'd1};
               end
            end

            default: begin
               state       <= IDLE;
               cpu_rdy_q   <= 1'b1;
               bus_grant_q <= 1'b0;
               dma_addr_q  <= '0;
               dma_wdata_q <= '0;
               dma_wr_q    <= 1'b0;
               dma_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_rdy   = cpu_rdy_q;
   assign bus.bus_grant = bus_grant_q;
   assign bus.dma_addr  = dma_addr_q;
   assign bus.dma_wdata = dma_wdata_q;
   assign bus.dma_wr    = dma_wr_q;
   assign bus.dma_busy  = dma_busy_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller. Expected READ addresses and
// WRITE bytes are queued at each trigger and consumed by a bus monitor.
// Build with OAM_DMA_ALIGN_EN defined to expect parity alignment cycles.
`timescale 1ns/1ps
module tb_oam_dma_controller;
   import nes_bus_pkg::*;

   logic clk_ph1 = 1'b0;
   logic rst     = 1'b0;

   oam_dma_controller_if bus ();

   oam_dma_controller dut (
      .clk_ph1 (clk_ph1),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk_ph1 = ~clk_ph1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory model: byte at {page,cnt} is cnt ^ A5
   always_comb bus.bus_rdata = bus.bus_grant ? (bus.dma_addr[7:0] ^ 8'hA5) : 8'h00;

   int cyc = 0;
   always @(posedge clk_ph1) cyc <= cyc + 1;

   // Reference cycle parity: 0 out of reset, toggles every clock
   logic m_par;
   always @(posedge clk_ph1 or negedge rst) begin
      if (!rst) m_par <= 1'b0;
      else      m_par <= ~m_par;
   end

   logic [15:0] rd_q[$];
   logic [7:0]  wr_q[$];
   logic [15:0] exp_a;
   logic [7:0]  exp_d;
   int          first_rd = -1;
   bit          armed    = 1'b0;
   int          unexp    = 0;

   // Bus monitor, sampled mid-cycle
   always @(negedge clk_ph1) begin
      if (bus.bus_grant && !bus.dma_wr) begin
         if (armed && first_rd < 0) first_rd = cyc;
         if (rd_q.size() == 0) begin
            unexp++;
         end else begin
            exp_a = rd_q.pop_front();
            check("rd_addr", 32'(bus.dma_addr), 32'(exp_a));
         end
      end else if (bus.dma_wr) begin
         if (wr_q.size() == 0) begin
            unexp++;
         end else begin
            exp_d = wr_q.pop_front();
            check("wr_cycle", 32'({bus.bus_grant, bus.dma_addr, bus.dma_wdata}),
                  32'({1'b1, OAM_DATA_ADDR, exp_d}));
         end
      end else begin
         check("idle_outs", 32'({bus.bus_grant, bus.dma_wr, bus.dma_addr, bus.dma_wdata}), 32'd0);
      end
   end

   task automatic run_dma(input logic [7:0] pg, input int hold, input logic want_par,
                          input int retrig, input bit do_abort);
      int  t0;
      int  x;
      bit  done;
      @(negedge clk_ph1);
      // Pick the trigger cycle so HALT exits with the wanted parity
      for (int i = 0; i < 2; i++) begin
         if ((m_par ^ 1'b1 ^ hold[0]) == want_par) break;
         @(negedge clk_ph1);
      end
`ifdef OAM_DMA_ALIGN_EN
      x = want_par ? 1 : 0;
`else
      x = 0;
`endif
      bus.cpu_addr  = DMA_TRIG_ADDR;
      bus.cpu_wdata = pg;
      bus.cpu_wr    = 1'b1;
      for (int c = 0; c < 256; c++) begin
         rd_q.push_back({pg, 8'(c)});
         wr_q.push_back(8'(c) ^ 8'hA5);
      end
      first_rd = -1;
      armed    = 1'b1;
      unexp    = 0;
      @(posedge clk_ph1);
      #1;
      t0   = cyc;
      done = 1'b0;
      for (int n = 1; n <= 1200 && !done; n++) begin
         @(negedge clk_ph1);
         if (n == 1) check("halt_entry", 32'({bus.cpu_rdy, bus.dma_busy}), 32'b01);
         if (bus.cpu_rdy && n > 1) begin
            check("cycles_to_rdy", 32'(cyc - t0), 32'(513 + hold + x));
            check("busy_clear", 32'(bus.dma_busy), 32'd0);
            check("first_read", 32'(first_rd - t0), 32'(1 + hold + x));
            done = 1'b1;
         end
         bus.cpu_wr    = 1'b0;
         bus.cpu_addr  = 16'h0000;
         bus.cpu_wdata = 8'h00;
         if (n <= hold) begin
            bus.cpu_wr    = 1'b1;
            bus.cpu_addr  = 16'h0300;
            bus.cpu_wdata = 8'h11;
         end
         if (n == retrig) begin
            bus.cpu_wr    = 1'b1;
            bus.cpu_addr  = DMA_TRIG_ADDR;
            bus.cpu_wdata = 8'h55;
         end
         if (do_abort && !done && (cyc - t0) == 201 + hold + x) begin
            #1 rst = 1'b0;
            #1 check("reset_outs",
                     32'({bus.cpu_rdy, bus.bus_grant, bus.dma_wr, bus.dma_busy, bus.dma_addr, bus.dma_wdata}),
                     32'h800_0000);
            @(negedge clk_ph1);
            rst = 1'b1;
            rd_q.delete();
            wr_q.delete();
            armed = 1'b0;
            repeat (20) begin
               @(negedge clk_ph1);
               check("post_rst", 32'({bus.cpu_rdy, bus.dma_busy, bus.bus_grant, bus.dma_wr}), 32'b1000);
            end
            done = 1'b1;
         end
      end
      if (!done) check("rdy_timeout", 32'(bus.cpu_rdy), 32'd1);
      check("rd_left", 32'(rd_q.size()), 32'd0);
      check("wr_left", 32'(wr_q.size()), 32'd0);
      check("unexpected", 32'(unexp), 32'd0);
      armed = 1'b0;
   endtask

   initial begin
      bus.cpu_addr  = 16'h0000;
      bus.cpu_wdata = 8'h00;
      bus.cpu_wr    = 1'b0;
      repeat (3) @(negedge clk_ph1);
      check("reset_state",
            32'({bus.cpu_rdy, bus.bus_grant, bus.dma_wr, bus.dma_busy, bus.dma_addr, bus.dma_wdata}),
            32'h800_0000);
      rst = 1'b1;
      repeat (3) @(negedge clk_ph1);

      run_dma(8'h02, 0, 1'b0, 0, 1'b0);   // parity 0 at HALT exit
      run_dma(8'h02, 0, 1'b1, 0, 1'b0);   // parity 1 at HALT exit
      run_dma(8'h02, 2, 1'b0, 0, 1'b0);   // CPU write extends HALT
      run_dma(8'h02, 0, 1'b0, 60, 1'b0);  // second trigger mid-transfer
      run_dma(8'h02, 0, 1'b0, 0, 1'b1);   // reset at byte 100
      run_dma(8'h7F, 0, 1'b1, 0, 1'b0);   // clean transfer after abort

      repeat (2) @(negedge clk_ph1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
